sig_meas: RTL

Receive-side counterpart of the on-board waveform generator. Captures 8-bit ADC samples, one per clock, and drives ad_clk to the ADC. On a start request it learns the signal's min/max, derives a mid-level threshold with hysteresis, then measures one period (or four, with the optional feature). It reports period, high time, min, max and peak-to-peak, for loop-back checking of generator settings (frequency, duty, amplitude).

---
 rtl/sig_meas.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sig_meas.sv
// sig_meas: loop-back signal measurement for the on-board waveform generator.
// Samples 8-bit unsigned ADC data once per clk, learns min/max over a training
// window, derives a mid-level threshold with hysteresis, then measures the
// period and high time of the signal along with min, max and peak-to-peak.
//
// Optional build macro: SIG_MEAS_AVG4_EN -- average four consecutive periods
// (14-bit accumulators, truncated divide by four). Undefined: one period.
//
// Ports:
//   clk       system clock, also the ADC sample clock
//   rst_n     asynchronous active-low reset
//   ad_data   ADC sample, unsigned, valid every clk
//   ad_clk    ADC clock (copy of clk)
//   start     single-cycle measurement request (ignored unless idle)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse when a measurement finishes
//   err       0 ok, 1 flat signal, 2 timeout (holds until the next start)
//   period    samples per period
//   high_cnt  samples at high level within the period
//   vmax/vmin extreme samples seen during TRAIN and MEAS
//   vpp       vmax - vmin
//
// state | meaning
// IDLE  | waiting for start, running min/max held at 255/0
// TRAIN | WIN samples to learn min/max
// SYNC  | waiting for the first rising edge
// MEAS  | counting samples until the closing rising edge
// DONE  | publish results / error, pulse done
module sig_meas #(
  parameter int WIN     = 1024,
  parameter int MAX_PER = 4095,
  parameter int HYST    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ad_data,
  output logic        ad_clk,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [11:0] period,
  output logic [11:0] high_cnt,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp
);

  localparam logic [11:0] WIN12     = 12'(WIN);
  localparam logic [11:0] MAX_PER12 = 12'(MAX_PER);

  typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_SYNC, S_MEAS, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  smp;
  logic [7:0]  run_min, run_max, mn_nxt, mx_nxt, span;
  logic [7:0]  thr_new, thr_hi_new, thr_lo_new, thr_hi, thr_lo;
  logic [8:0]  hi9;
  logic        flat, lvl, lvl_nxt, rise, last_per;
  logic [11:0] tmr, per_cnt, hi_cnt, per_inc, per_lat, hi_lat;
  logic [1:0]  code;

`ifdef SIG_MEAS_AVG4_EN
  logic [13:0] acc_per, acc_hi, per_sum, hi_sum;
  logic [1:0]  n_per;
  assign per_sum  = acc_per + {2'b00, per_cnt};
  assign hi_sum   = acc_hi + {2'b00, hi_cnt};
  assign last_per = (n_per == 2'd3);
`else
  assign last_per = 1'b1;
`endif

  assign ad_clk = clk;

  always_comb begin
    state_nxt  = state;
    mn_nxt     = (smp < run_min) ? smp : run_min;
    mx_nxt     = (smp > run_max) ? smp : run_max;
    span       = mx_nxt - mn_nxt;
    flat       = ({1'b0, span} < 9'(2 * HYST + 1));
    thr_new    = 8'((9'(mn_nxt) + 9'(mx_nxt)) >> 1);
    hi9        = {1'b0, thr_new} + 9'(HYST);
    thr_hi_new = hi9[8] ? 8'hFF : hi9[7:0];
    thr_lo_new = (thr_new < 8'(HYST)) ? 8'h00 : thr_new - 8'(HYST);
    rise       = ~lvl & (smp >= thr_hi);
    lvl_nxt    = lvl;
    if (rise)
      lvl_nxt = 1'b1;
    else if (lvl && (smp <= thr_lo))
      lvl_nxt = 1'b0;
    per_inc    = per_cnt + 12'd1;
    case (state)
      S_IDLE:  if (start) state_nxt = S_TRAIN;
      S_TRAIN: if (tmr == 12'd1) state_nxt = flat ? S_DONE : S_SYNC;
      S_SYNC: begin
        if (rise)
          state_nxt = S_MEAS;
        else if (tmr == 12'd1)
          state_nxt = S_DONE;
      end
      S_MEAS: begin
        if (rise) begin
          if (last_per) state_nxt = S_DONE;
        end else if (per_inc == MAX_PER12) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp      <= 8'h00;
      run_min  <= 8'hFF;
      run_max  <= 8'h00;
      thr_hi   <= 8'h00;
      thr_lo   <= 8'h00;
      lvl      <= 1'b0;
      tmr      <= 12'd0;
      per_cnt  <= 12'd0;
      hi_cnt   <= 12'd0;
      per_lat  <= 12'd0;
      hi_lat   <= 12'd0;
      code     <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 2'd0;
      period   <= 12'd0;
      high_cnt <= 12'd0;
      vmax     <= 8'h00;
      vmin     <= 8'h00;
      vpp      <= 8'h00;
`ifdef SIG_MEAS_AVG4_EN
      acc_per  <= 14'd0;
      acc_hi   <= 14'd0;
      n_per    <= 2'd0;
`endif
    end else begin
      smp  <= ad_data;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          run_min <= 8'hFF;
          run_max <= 8'h00;
          if (start) begin
            tmr     <= WIN12;
            per_cnt <= 12'd0;
            hi_cnt  <= 12'd0;
            code    <= 2'd0;
            err     <= 2'd0;
            busy    <= 1'b1;
          end
        end
        S_TRAIN: begin
          run_min <= mn_nxt;
          run_max <= mx_nxt;
          tmr     <= tmr - 12'd1;
          if (tmr == 12'd1) begin
            thr_hi <= thr_hi_new;
            thr_lo <= thr_lo_new;
            // initial level uses the bare threshold, not the hysteresis band
            lvl    <= (smp >= thr_new);
            tmr    <= MAX_PER12;
            if (flat) code <= 2'd1;
          end
        end
        S_SYNC: begin
          lvl <= lvl_nxt;
          tmr <= tmr - 12'd1;
          if (rise) begin
            per_cnt <= 12'd1;
            hi_cnt  <= 12'd1;
`ifdef SIG_MEAS_AVG4_EN
            acc_per <= 14'd0;
            acc_hi  <= 14'd0;
            n_per   <= 2'd0;
`endif
          end else if (tmr == 12'd1) begin
            code <= 2'd2;
          end
        end
        S_MEAS: begin
          lvl     <= lvl_nxt;
          run_min <= mn_nxt;
          run_max <= mx_nxt;
          per_cnt <= per_inc;
          if (lvl_nxt) hi_cnt <= hi_cnt + 12'd1;
          // the rise sample opens the next period, so the counts before it are exact
          if (rise) begin
`ifdef SIG_MEAS_AVG4_EN
            acc_per <= per_sum;
            acc_hi  <= hi_sum;
            n_per   <= n_per + 2'd1;
            per_cnt <= 12'd1;
            hi_cnt  <= 12'd1;
            per_lat <= 12'(per_sum >> 2);
            hi_lat  <= 12'(hi_sum >> 2);
`else
            per_lat <= per_cnt;
            hi_lat  <= hi_cnt;
`endif
          end else if (per_inc == MAX_PER12) begin
            code <= 2'd2;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          err  <= code;
          if (code == 2'd0) begin
            period   <= per_lat;
            high_cnt <= hi_lat;
            vmax     <= run_max;
            vmin     <= run_min;
            vpp      <= run_max - run_min;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
